uart_tx_arbiter: RTL

Shares one `uart_tx` serializer between `NUM_REQ` byte requesters. Round-robin, one byte per grant. It drives the transmitter's `start`/`data` inputs and tracks its `in_progress` output to know when the line is free. It sits between the byte producers (command, log, echo paths) and the single `uart_tx` instance.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter.
// Holds the arbiter state enum and the data/requester width limits.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY
    } uart_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches upward from last_ptr_i+1 with wrap; first valid lane wins.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] last_ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Walk N candidates after the last owner; keep the first hit.
    always_comb begin
        int c;
        c        = 0;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last_ptr_i) + k) % N;
            if (!any_o && valid_i[IW'(c)]) begin
                any_o              = 1'b1;
                onehot_o[IW'(c)]   = 1'b1;
                idx_o              = IW'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between requesters.
// Optional UART_TX_ARB_LOCK_EN adds req_lock for unbroken multi-byte runs.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             req_lock,
`endif
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic [UART_DATA_W-1:0]         tx_data,
    output logic                           tx_start,
    input  logic                           tx_busy,
    output logic                           timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [7:0] TMO_LAST = 8'(START_TIMEOUT - 1);

    uart_arb_state_t        state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [IW-1:0]          last_q, last_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic                   terr_q, terr_d;

    logic [NUM_REQ-1:0]     pick_oh;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .valid_i    (req_valid),
        .last_ptr_i (last_q),
        .onehot_o   (pick_oh),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    // Next-state, owner bookkeeping and start-timeout handling.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ready_d = '0;
        terr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any && !tx_busy) begin
                    state_d = START;
                    grant_d = pick_oh;
                    idx_d   = pick_idx;
                    data_d  = req_data[pick_idx*UART_DATA_W +: UART_DATA_W];
                    ready_d = pick_oh;
                    cnt_d   = '0;
                end
            end
            START: begin
                cnt_d = cnt_q + 8'd1;
                if (tx_busy) begin
                    state_d = BUSY;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = idx_q;
                    terr_d  = 1'b1;
                end
            end
            BUSY: begin
                if (!tx_busy) begin
`ifdef UART_TX_ARB_LOCK_EN
                    if (req_lock[idx_q] && req_valid[idx_q]) begin
                        state_d = START;
                        data_d  = req_data[idx_q*UART_DATA_W +: UART_DATA_W];
                        ready_d = grant_q;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        last_d  = idx_q;
                    end
`else
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = idx_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            data_q  <= '0;
            cnt_q   <= '0;
            ready_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            terr_q  <= terr_d;
        end
    end

    assign tx_start    = (state_q == START);
    assign grant       = grant_q;
    assign tx_data     = data_q;
    assign req_ready   = ready_q;
    assign timeout_err = terr_q;

endmodule
